// File: rtl/pe_array_drain.sv
// Collects one LANE_W result group per PE lane, then replays the groups in lane
// order as a valid/ready stream. Define PE_DRAIN_DUP_CHECK_EN to build the sticky err_dup detector.
module pe_array_drain #(
    parameter int  N_PE   = 16,
    parameter int  LANE_W = 256,
    localparam int IDX_W  = (N_PE > 1) ? $clog2(N_PE) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_PE-1:0]        pe_valid_vec,
    input  logic [N_PE*LANE_W-1:0] pe_data,
    output logic                   pe_ready,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [LANE_W-1:0]      m_data,
    output logic                   m_last,
    output logic [IDX_W-1:0]       m_lane,
    output logic                   busy,
    output logic                   err_dup
);
    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

    state_t            state_q;
    logic [N_PE-1:0]   mask_q;
    logic [IDX_W-1:0]  idx_q;
    logic              ready_q;
    logic              valid_q;
    logic              last_q;
    logic [LANE_W-1:0] buf_q [N_PE];

    logic [N_PE-1:0]   cap_d;
    logic              all_in_d;
    logic              accept_d;
    logic              final_beat_d;

    // Only lanes not yet holding data this frame are written; repeats are dropped.
    assign cap_d        = (state_q == COLLECT) ? (pe_valid_vec & ~mask_q) : '0;
    assign all_in_d     = &(mask_q | cap_d);
    assign accept_d     = valid_q & m_ready;
    assign final_beat_d = (idx_q == IDX_W'(N_PE - 1));

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_PE; i++) begin
            if (cap_d[i]) begin
                buf_q[i] <= pe_data[i*LANE_W +: LANE_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mask_q  <= '0;
            idx_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= COLLECT;
                    ready_q <= 1'b1;
                end
                COLLECT: begin
                    mask_q <= mask_q | cap_d;
                    if (all_in_d) begin
                        state_q <= DRAIN;
                        ready_q <= 1'b0;
                        valid_q <= 1'b1;
                        idx_q   <= '0;
                        last_q  <= (N_PE == 1);
                    end
                end
                DRAIN: begin
                    if (accept_d) begin
                        if (final_beat_d) begin
                            state_q <= COLLECT;
                            ready_q <= 1'b1;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            idx_q   <= '0;
                            mask_q  <= '0;
                        end else begin
                            idx_q  <= idx_q + IDX_W'(1);
                            last_q <= ((idx_q + IDX_W'(1)) == IDX_W'(N_PE - 1));
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pe_ready = ready_q;
    assign m_valid  = valid_q;
    assign busy     = valid_q;
    assign m_lane   = idx_q;
    assign m_last   = last_q;
    // Gated so the stream reads zero outside DRAIN, including during reset.
    assign m_data   = valid_q ? buf_q[idx_q] : '0;

`ifdef PE_DRAIN_DUP_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if ((state_q == COLLECT) && (|(pe_valid_vec & mask_q))) begin
            err_q <= 1'b1;
        end
    end

    assign err_dup = err_q;
`else
    assign err_dup = 1'b0;
`endif

endmodule

// File: tb/tb_pe_array_drain.sv
// Bench for pe_array_drain: a beat-queue model checked every cycle plus directed frame checks.
module tb_pe_array_drain;
    localparam int N = 16;
    localparam int W = 256;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   pe_valid_vec = '0;
    logic [N*W-1:0] pe_data = '0;
    logic           m_ready = 1'b1;
    logic           pe_ready, m_valid, m_last, busy, err_dup;
    logic [W-1:0]   m_data;
    logic [3:0]     m_lane;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int         lane;
        logic [W-1:0] data;
    } beat_t;

    beat_t        exp_q[$];
    logic [W-1:0] held [N];
    logic [N-1:0] have = '0;
    bit           started = 1'b0;
    bit           exp_err = 1'b0;
    bit           exp_ready, exp_valid;
    beat_t        nb;
    int           acc_lane[$];
    logic [W-1:0] acc_data[$];

    pe_array_drain dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pe_valid_vec (pe_valid_vec),
        .pe_data      (pe_data),
        .pe_ready     (pe_ready),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .m_lane       (m_lane),
        .busy         (busy),
        .err_dup      (err_dup)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] pat(int lane, int tag);
        logic [15:0] w;
        w = {tag[7:0], lane[7:0]};
        return {16{w}};
    endfunction

    task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model: the array is a set of per-lane slots; a full set becomes 16 queued beats.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            have    = '0;
            started = 1'b0;
            exp_err = 1'b0;
            chk("rst_pe_ready", W'(pe_ready), '0);
            chk("rst_m_valid",  W'(m_valid),  '0);
            chk("rst_m_last",   W'(m_last),   '0);
            chk("rst_m_lane",   W'(m_lane),   '0);
            chk("rst_m_data",   m_data,       '0);
            chk("rst_busy",     W'(busy),     '0);
            chk("rst_err_dup",  W'(err_dup),  '0);
        end else begin
            exp_valid = (exp_q.size() != 0);
            exp_ready = started && !exp_valid;
            chk("pe_ready", W'(pe_ready), W'(exp_ready));
            chk("m_valid",  W'(m_valid),  W'(exp_valid));
            chk("busy",     W'(busy),     W'(exp_valid));
            chk("err_dup",  W'(err_dup),  W'(exp_err));
            if (exp_valid) begin
                chk("m_lane", W'(m_lane), W'(exp_q[0].lane));
                chk("m_data", m_data, exp_q[0].data);
                chk("m_last", W'(m_last), W'(exp_q[0].lane == N - 1));
            end
            if (m_valid && m_ready) begin
                acc_lane.push_back(int'(m_lane));
                acc_data.push_back(m_data);
            end
            if (exp_ready) begin
                for (int i = 0; i < N; i++) begin
                    if (pe_valid_vec[i]) begin
                        if (have[i]) begin
`ifdef PE_DRAIN_DUP_CHECK_EN
                            exp_err = 1'b1;
`endif
                        end else begin
                            have[i] = 1'b1;
                            held[i] = pe_data[i*W +: W];
                        end
                    end
                end
                if (&have) begin
                    for (int i = 0; i < N; i++) begin
                        nb.lane = i;
                        nb.data = held[i];
                        exp_q.push_back(nb);
                    end
                    have = '0;
                end
            end else if (exp_valid && m_ready) begin
                void'(exp_q.pop_front());
            end
            started = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(logic [N-1:0] vv, int tag);
        pe_valid_vec = vv;
        for (int i = 0; i < N; i++) pe_data[i*W +: W] = pat(i, tag);
    endtask

    task automatic clear_log();
        acc_lane.delete();
        acc_data.delete();
    endtask

    task automatic run_drain(int n, bit stall);
        int c;
        c = 0;
        while (acc_lane.size() < n && c < 400) begin
            if (stall) m_ready = ((c % 4) == 0) || ((c % 4) == 3);
            else       m_ready = 1'b1;
            step();
            c++;
        end
        m_ready = 1'b1;
        chk("drain_beat_count", W'(acc_lane.size()), W'(n));
    endtask

    task automatic check_frame(string name, int base, int tag);
        for (int i = 0; i < N; i++) begin
            chk({name, "_lane"}, W'(acc_lane[base + i]), W'(i));
            chk({name, "_data"}, acc_data[base + i], pat(i, tag));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ord [N] = '{15, 3, 0, 1, 2, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14};
        logic [N-1:0] vv;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("t0_ready_idle", W'(pe_ready), '0);
        step();
        chk("t0_ready_rise", W'(pe_ready), W'(1));
        step();

        // All lanes at once, free-running sink.
        clear_log();
        set_lanes('1, 0);
        step();
        pe_valid_vec = '0;
        chk("t1_ready_drop", W'(pe_ready), '0);
        chk("t1_valid_rise", W'(m_valid), W'(1));
        chk("t1_first_lane", W'(m_lane), '0);
        run_drain(16, 1'b0);
        chk("t1_ready_back", W'(pe_ready), W'(1));
        check_frame("t1", 0, 0);
        chk("t1_beat3_lit", acc_data[3], {16{16'h0003}});
        step();

        // One lane per cycle, out of order.
        clear_log();
        for (int k = 0; k < N; k++) begin
            vv = '0;
            vv[ord[k]] = 1'b1;
            set_lanes(vv, 2);
            step();
            if (k < N - 1) chk("t2_no_valid_early", W'(m_valid), '0);
            else           chk("t2_valid_after_last", W'(m_valid), W'(1));
        end
        pe_valid_vec = '0;
        run_drain(16, 1'b0);
        check_frame("t2", 0, 2);
        chk("t2_beat15_lit", acc_data[15], {16{16'h020f}});
        step();

        // Stalling sink 1,0,0,1.
        clear_log();
        set_lanes('1, 3);
        step();
        pe_valid_vec = '0;
        run_drain(16, 1'b1);
        check_frame("t3", 0, 3);
        step();

        // Lane 5 repeated: first data must win.
        clear_log();
        set_lanes(16'h0020, 4);
        step();
        set_lanes(16'h0020, 5);
        step();
        set_lanes('1, 5);
        step();
        pe_valid_vec = '0;
        run_drain(16, 1'b0);
        chk("t4_beat5_lit", acc_data[5], {16{16'h0405}});
        chk("t4_beat6_lit", acc_data[6], {16{16'h0506}});
`ifdef PE_DRAIN_DUP_CHECK_EN
        chk("t4_err_dup", W'(err_dup), W'(1));
`else
        chk("t4_err_dup", W'(err_dup), '0);
`endif
        step();

        // Valid held through a drain; new data must not leak in until COLLECT.
        clear_log();
        set_lanes('1, 6);
        step();
        chk("t5_valid", W'(m_valid), W'(1));
        set_lanes('1, 7);
        for (int c = 0; c < 40; c++) begin
            step();
            if (!m_valid) break;
        end
        chk("t5_ready_after_frame", W'(pe_ready), W'(1));
        step();
        chk("t5_recapture", W'(m_valid), W'(1));
        pe_valid_vec = '0;
        run_drain(32, 1'b0);
        check_frame("t5a", 0, 6);
        check_frame("t5b", 16, 7);
`ifdef PE_DRAIN_DUP_CHECK_EN
        chk("t5_err_sticky", W'(err_dup), W'(1));
`else
        chk("t5_err_sticky", W'(err_dup), '0);
`endif
        step();

        // Reset in the middle of a drain.
        clear_log();
        set_lanes('1, 8);
        step();
        pe_valid_vec = '0;
        for (int c = 0; c < 60; c++) begin
            if (m_valid && m_lane == 4'd7) break;
            step();
        end
        chk("t6_at_beat7", W'(m_lane), W'(7));
        rst_n = 1'b0;
        #1;
        chk("t6_valid_async", W'(m_valid), '0);
        chk("t6_ready_async", W'(pe_ready), '0);
        chk("t6_lane_async", W'(m_lane), '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        step();
        clear_log();
        set_lanes(16'h7fff, 9);
        step();
        pe_valid_vec = '0;
        step();
        chk("t6_partial_no_valid", W'(m_valid), '0);
        set_lanes(16'h8000, 9);
        step();
        pe_valid_vec = '0;
        chk("t6_valid", W'(m_valid), W'(1));
        chk("t6_first_lane", W'(m_lane), '0);
        run_drain(16, 1'b0);
        check_frame("t6", 0, 9);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
